collision_detector: RTL and testbench
=====================================

# collision_detector

Per-pixel collision detector for the main screen. It samples the same per-pixel draw requests that the screen's priority mux composites, and flags every pixel where the ball (smiley) overlaps a flipper, obstacle, spring or bumper. Hits are accumulated over one video frame. At the next frame boundary a qualified hit is presented as a single valid/ack report to the ball-physics logic.

## Interface
- PIXEL_X_W, 11, width of pixelX
- PIXEL_Y_W, 11, width of pixelY
- COUNT_W, 8, width of the overlap-pixel counter
- MIN_HIT_PIXELS, 2, minimum overlap pixels per frame for a frame to count as a hit (range 1..2^COUNT_W-1)

Ports:
- clk  in  1  pixel clock
- resetN  in  1  reset; asynchronous, active-low
- startOfFrame  in  1  one-cycle pulse on the first pixel of each frame
- pixelX  in  PIXEL_X_W  current pixel column
- pixelY  in  PIXEL_Y_W  current pixel row
- draw_smiley  in  1  ball occupies the current pixel
- draw_flipper  in  1  flipper occupies the current pixel
- drawObstacle  in  1  obstacle occupies the current pixel
- drawSpring  in  1  spring occupies the current pixel
- drawBumper  in  1  bumper occupies the current pixel
- hit_ack  in  1  consumer has taken the report
- hit_valid  out  1  report pending
- hit_type  out  4  objects touched in the reported frame: {bumper, spring, obstacle, flipper}
- hit_first  out  4  one-hot type at the first overlap pixel of the frame
- hit_x  out  PIXEL_X_W  column of the first overlap pixel
- hit_y  out  PIXEL_Y_W  row of the first overlap pixel
- hit_count  out  COUNT_W  overlap pixels in the reported frame
- hit_dropped  out  1  one-cycle pulse when an unacknowledged report is overwritten

## Operation
- Overlap pixel: draw_smiley=1 and at least one of flipper/obstacle/spring/bumper is 1.
- Each cycle is one pixel; blanking cycles carry all draws at 0.
- Accumulators, internal, per frame:
  - acc_type: OR of all overlapping object bits.
  - acc_cnt: count of overlap pixels, saturating at 2^COUNT_W-1.
  - acc_first, acc_x, acc_y: captured on the first overlap pixel only, while acc_cnt==0.
- acc_first priority when several objects overlap the ball at one pixel: flipper > obstacle > spring > bumper. Exactly one bit is set.
- Report FSM, two states:
  - EMPTY: hit_valid=0.
  - PENDING: hit_valid=1; report outputs stable.
- At startOfFrame the closing frame is evaluated. A frame qualifies if acc_cnt >= MIN_HIT_PIXELS.
  - Qualified: load hit_* from the accumulators; next state PENDING.
  - Not qualified: report registers and state unchanged, except as modified by hit_ack.
- The startOfFrame pixel belongs to the new frame. Accumulators reload with that pixel's contribution only, not cleared to zero.
- hit_ack while PENDING: next state EMPTY. hit_ack while EMPTY is ignored.
- Qualified load while PENDING without hit_ack in that cycle: overwrite the report and pulse hit_dropped for one cycle.
- Qualified load while PENDING with hit_ack in the same cycle: load the new report, stay PENDING, no hit_dropped.
- Report outputs keep their last values in EMPTY. Consumers qualify them with hit_valid.
- Reset values: hit_valid=0, hit_type=0, hit_first=0, hit_x=0, hit_y=0, hit_count=0, hit_dropped=0, state EMPTY, all accumulators 0.
- Reset mid-frame discards the partial frame. The first startOfFrame after reset never qualifies unless overlaps occur after reset.

## Timing
- All outputs are registered; there is no combinational input-to-output path.
- Report latency: hit_valid rises on the clock edge that samples startOfFrame, so it is visible the cycle after the startOfFrame pulse.
- Data becomes valid in the same cycle as hit_valid.
- hit_valid falls on the edge that samples hit_ack, unless a qualified load occurs on that same edge.
- hit_dropped is asserted for exactly the one cycle following the overwriting startOfFrame.
- Throughput: at most one report per frame; hit_ack may be held high continuously.

## Test plan
- Single overlap: ball over flipper at (100,200) for 3 consecutive pixels, then startOfFrame, no ack → next cycle hit_valid=1, hit_type=0001, hit_first=0001, hit_x=100, hit_y=200, hit_count=3; hit_valid stays high until hit_ack, then 0 one cycle after ack.
- Threshold and priority: one overlap pixel with flipper+bumper at (50,60), then startOfFrame → hit_valid stays 0. Next frame has the same pixel plus one bumper-only pixel at (51,60) → hit_type=1001, hit_first=0001, hit_x=50, hit_count=2.
- Overwrite: qualified frame A, no ack, qualified frame B (first pixel (10,20)) → at B's startOfFrame, hit_dropped pulses for 1 cycle and hit_x=10. Repeat with hit_ack high in the B startOfFrame cycle → no hit_dropped, hit_valid stays 1.
- Boundary pixel: overlap (obstacle) occurring exactly in a startOfFrame cycle, none elsewhere → excluded from the closing frame, counted in the new frame. With MIN_HIT_PIXELS=1, the following startOfFrame reports hit_count=1 and hit_type=0010.
- Saturation: COUNT_W=4, 20 overlap pixels in one frame → hit_count=15.
- Reset: resetN low mid-frame after 5 overlap pixels, released, then startOfFrame → all outputs 0, no report.

Source files
------------

// File: rtl/collision_detector.sv
// Per-pixel ball/object overlap detector for the main screen.
// Accumulates hits over a frame and reports qualified frames via valid/ack.
module collision_detector #(
    parameter int PIXEL_X_W      = 11,
    parameter int PIXEL_Y_W      = 11,
    parameter int COUNT_W        = 8,
    parameter int MIN_HIT_PIXELS = 2
) (
    input  logic                 clk,
    input  logic                 resetN,
    input  logic                 startOfFrame,
    input  logic [PIXEL_X_W-1:0] pixelX,
    input  logic [PIXEL_Y_W-1:0] pixelY,
    input  logic                 draw_smiley,
    input  logic                 draw_flipper,
    input  logic                 drawObstacle,
    input  logic                 drawSpring,
    input  logic                 drawBumper,
    input  logic                 hit_ack,
    output logic                 hit_valid,
    output logic [3:0]           hit_type,
    output logic [3:0]           hit_first,
    output logic [PIXEL_X_W-1:0] hit_x,
    output logic [PIXEL_Y_W-1:0] hit_y,
    output logic [COUNT_W-1:0]   hit_count,
    output logic                 hit_dropped
);

    typedef enum logic {
        EMPTY,
        PENDING
    } state_t;

    localparam logic [COUNT_W-1:0] MIN_CNT = COUNT_W'(MIN_HIT_PIXELS);

    state_t               state, state_nxt;
    logic                 dropped_nxt;
    logic                 overlap;
    logic                 qualify;
    logic [3:0]           obj;
    logic [3:0]           first_oh;
    logic [3:0]           acc_type;
    logic [3:0]           acc_first;
    logic [COUNT_W-1:0]   acc_cnt;
    logic [PIXEL_X_W-1:0] acc_x;
    logic [PIXEL_Y_W-1:0] acc_y;

    assign obj       = {drawBumper, drawSpring, drawObstacle, draw_flipper};
    assign overlap   = draw_smiley & (|obj);
    assign qualify   = startOfFrame & (acc_cnt >= MIN_CNT);
    assign hit_valid = (state == PENDING);

    // One-hot of the highest-priority object: flipper > obstacle > spring > bumper
    always_comb begin
        first_oh = 4'b0000;
        priority case (1'b1)
            obj[0]:  first_oh = 4'b0001;
            obj[1]:  first_oh = 4'b0010;
            obj[2]:  first_oh = 4'b0100;
            obj[3]:  first_oh = 4'b1000;
            default: first_oh = 4'b0000;
        endcase
    end

    // Per-frame accumulators; the startOfFrame pixel seeds the new frame
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            acc_type  <= '0;
            acc_first <= '0;
            acc_cnt   <= '0;
            acc_x     <= '0;
            acc_y     <= '0;
        end else if (startOfFrame) begin
            acc_type  <= overlap ? obj : 4'b0000;
            acc_first <= overlap ? first_oh : 4'b0000;
            acc_cnt   <= overlap ? COUNT_W'(1) : '0;
            acc_x     <= overlap ? pixelX : '0;
            acc_y     <= overlap ? pixelY : '0;
        end else if (overlap) begin
            acc_type <= acc_type | obj;
            if (acc_cnt != '1) begin
                acc_cnt <= acc_cnt + COUNT_W'(1);
            end
            if (acc_cnt == '0) begin
                acc_first <= first_oh;
                acc_x     <= pixelX;
                acc_y     <= pixelY;
            end
        end
    end

    // Report state register
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Next report state and overwrite detection
    always_comb begin
        state_nxt   = state;
        dropped_nxt = 1'b0;
        unique case (state)
            EMPTY: begin
                if (qualify) begin
                    state_nxt = PENDING;
                end
            end
            PENDING: begin
                if (qualify) begin
                    dropped_nxt = ~hit_ack;
                end else if (hit_ack) begin
                    state_nxt = EMPTY;
                end
            end
            default: state_nxt = EMPTY;
        endcase
    end

    // Report registers load from the accumulators on a qualified frame
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            hit_type    <= '0;
            hit_first   <= '0;
            hit_x       <= '0;
            hit_y       <= '0;
            hit_count   <= '0;
            hit_dropped <= 1'b0;
        end else begin
            hit_dropped <= dropped_nxt;
            if (qualify) begin
                hit_type  <= acc_type;
                hit_first <= acc_first;
                hit_x     <= acc_x;
                hit_y     <= acc_y;
                hit_count <= acc_cnt;
            end
        end
    end

endmodule

// File: tb/tb_collision_detector.sv
// Scoreboard bench for collision_detector: directed frames push expected
// reports; a monitor pops and compares whenever a new report appears.
module tb_collision_detector;

    logic        clk = 1'b0;
    logic        resetN;
    logic        startOfFrame;
    logic [10:0] pixelX;
    logic [10:0] pixelY;
    logic        draw_smiley;
    logic        draw_flipper;
    logic        drawObstacle;
    logic        drawSpring;
    logic        drawBumper;
    logic        hit_ack;
    logic        hit_valid;
    logic [3:0]  hit_type;
    logic [3:0]  hit_first;
    logic [10:0] hit_x;
    logic [10:0] hit_y;
    logic [7:0]  hit_count;
    logic        hit_dropped;

    typedef struct {
        logic [3:0]  t;
        logic [3:0]  f;
        logic [10:0] x;
        logic [10:0] y;
        logic [7:0]  c;
        logic        d;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    logic pv = 1'b0;
    logic pa = 1'b0;

    collision_detector dut (
        .clk          (clk),
        .resetN       (resetN),
        .startOfFrame (startOfFrame),
        .pixelX       (pixelX),
        .pixelY       (pixelY),
        .draw_smiley  (draw_smiley),
        .draw_flipper (draw_flipper),
        .drawObstacle (drawObstacle),
        .drawSpring   (drawSpring),
        .drawBumper   (drawBumper),
        .hit_ack      (hit_ack),
        .hit_valid    (hit_valid),
        .hit_type     (hit_type),
        .hit_first    (hit_first),
        .hit_x        (hit_x),
        .hit_y        (hit_y),
        .hit_count    (hit_count),
        .hit_dropped  (hit_dropped)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One pixel cycle: sof, x, y, {bumper,spring,obstacle,flipper}, smiley, ack
    task automatic px(input logic sof, input int x, input int y,
                      input logic [3:0] o, input logic s, input logic a);
        startOfFrame = sof;
        pixelX       = 11'(x);
        pixelY       = 11'(y);
        draw_smiley  = s;
        draw_flipper = o[0];
        drawObstacle = o[1];
        drawSpring   = o[2];
        drawBumper   = o[3];
        hit_ack      = a;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) px(1'b0, 0, 0, 4'b0000, 1'b0, 1'b0);
    endtask

    task automatic push(input logic [3:0] t, input logic [3:0] f,
                        input int x, input int y, input int c,
                        input logic d);
        exp_t e;
        e.t = t; e.f = f; e.x = 11'(x); e.y = 11'(y);
        e.c = 8'(c); e.d = d;
        sb.push_back(e);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_valid"}, 32'(hit_valid), 0);
        chk({tag, "_type"}, 32'(hit_type), 0);
        chk({tag, "_first"}, 32'(hit_first), 0);
        chk({tag, "_x"}, 32'(hit_x), 0);
        chk({tag, "_y"}, 32'(hit_y), 0);
        chk({tag, "_count"}, 32'(hit_count), 0);
        chk({tag, "_dropped"}, 32'(hit_dropped), 0);
    endtask

    // Handshake history as seen by the DUT on each edge
    always @(posedge clk) begin
        pv <= hit_valid;
        pa <= hit_ack;
    end

    // Monitor: a new report is visible when valid rises, after an accepted
    // ack with valid still high, or on an overwrite
    always @(negedge clk) begin
        if (resetN && hit_valid && (!pv || pa || hit_dropped)) begin
            if (sb.size() == 0) begin
                chk("unexpected_report", 32'(hit_count), 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("rpt_type", 32'(hit_type), 32'(e.t));
                chk("rpt_first", 32'(hit_first), 32'(e.f));
                chk("rpt_x", 32'(hit_x), 32'(e.x));
                chk("rpt_y", 32'(hit_y), 32'(e.y));
                chk("rpt_count", 32'(hit_count), 32'(e.c));
                chk("rpt_dropped", 32'(hit_dropped), 32'(e.d));
            end
        end
    end

    initial begin
        resetN = 1'b0;
        startOfFrame = 1'b0;
        pixelX = '0; pixelY = '0;
        draw_smiley = 1'b0; draw_flipper = 1'b0; drawObstacle = 1'b0;
        drawSpring = 1'b0; drawBumper = 1'b0; hit_ack = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk_zero("reset");
        resetN = 1'b1;
        idle(2);

        // Single overlap: flipper at (100,200) for 3 pixels
        for (int i = 0; i < 3; i++) px(1'b0, 100, 200, 4'b0001, 1'b1, 1'b0);
        push(4'b0001, 4'b0001, 100, 200, 3, 1'b0);
        px(1'b1, 0, 0, 4'b0000, 1'b0, 1'b0);
        idle(3);
        chk("hold_valid", 32'(hit_valid), 1);
        px(1'b0, 0, 0, 4'b0000, 1'b0, 1'b1);
        chk("ack_clears", 32'(hit_valid), 0);
        chk("data_kept", 32'(hit_count), 3);
        px(1'b0, 0, 0, 4'b0000, 1'b0, 1'b1);
        idle(2);

        // Threshold: one pixel is not enough
        px(1'b0, 50, 60, 4'b1001, 1'b1, 1'b0);
        px(1'b1, 0, 0, 4'b0000, 1'b0, 1'b0);
        idle(2);
        chk("below_min", 32'(hit_valid), 0);
        // Priority: flipper wins first; bumper-only pixel adds to type
        px(1'b0, 50, 60, 4'b1001, 1'b1, 1'b0);
        px(1'b0, 51, 60, 4'b1000, 1'b1, 1'b0);
        push(4'b1001, 4'b0001, 50, 60, 2, 1'b0);
        px(1'b1, 0, 0, 4'b0000, 1'b0, 1'b0);
        idle(2);
        px(1'b0, 0, 0, 4'b0000, 1'b0, 1'b1);
        idle(2);

        // Overwrite without ack
        px(1'b0, 5, 5, 4'b0001, 1'b1, 1'b0);
        px(1'b0, 6, 5, 4'b0001, 1'b1, 1'b0);
        push(4'b0001, 4'b0001, 5, 5, 2, 1'b0);
        px(1'b1, 0, 0, 4'b0000, 1'b0, 1'b0);
        px(1'b0, 10, 20, 4'b0010, 1'b1, 1'b0);
        px(1'b0, 11, 20, 4'b0010, 1'b1, 1'b0);
        push(4'b0010, 4'b0010, 10, 20, 2, 1'b1);
        px(1'b1, 0, 0, 4'b0000, 1'b0, 1'b0);
        px(1'b0, 0, 0, 4'b0000, 1'b0, 1'b0);
        chk("drop_one_cycle", 32'(hit_dropped), 0);
        chk("drop_still_valid", 32'(hit_valid), 1);
        // Overwrite with ack in the same cycle
        px(1'b0, 30, 40, 4'b0100, 1'b1, 1'b0);
        px(1'b0, 31, 40, 4'b0100, 1'b1, 1'b0);
        push(4'b0100, 4'b0100, 30, 40, 2, 1'b0);
        px(1'b1, 0, 0, 4'b0000, 1'b0, 1'b1);
        chk("ack_load_valid", 32'(hit_valid), 1);
        chk("ack_load_nodrop", 32'(hit_dropped), 0);
        px(1'b0, 0, 0, 4'b0000, 1'b0, 1'b1);
        chk("ack_after_load", 32'(hit_valid), 0);
        idle(2);

        // Boundary: overlap on the startOfFrame pixel goes to the new frame
        px(1'b0, 70, 80, 4'b0010, 1'b1, 1'b0);
        px(1'b1, 71, 81, 4'b0010, 1'b1, 1'b0);
        idle(1);
        chk("boundary_excl", 32'(hit_valid), 0);
        px(1'b0, 72, 81, 4'b0010, 1'b1, 1'b0);
        push(4'b0010, 4'b0010, 71, 81, 2, 1'b0);
        px(1'b1, 0, 0, 4'b0000, 1'b0, 1'b0);
        px(1'b0, 0, 0, 4'b0000, 1'b0, 1'b1);
        idle(2);

        // Saturation: 260 overlaps clamp at 255
        for (int i = 0; i < 260; i++) px(1'b0, i, 5, 4'b0100, 1'b1, 1'b0);
        push(4'b0100, 4'b0100, 0, 5, 255, 1'b0);
        px(1'b1, 0, 0, 4'b0000, 1'b0, 1'b0);
        px(1'b0, 0, 0, 4'b0000, 1'b0, 1'b1);
        idle(2);

        // Reset mid-frame discards the partial frame and the old report
        for (int i = 0; i < 5; i++) px(1'b0, 200 + i, 9, 4'b0001, 1'b1, 1'b0);
        resetN = 1'b0;
        @(negedge clk);
        chk_zero("midreset");
        resetN = 1'b1;
        idle(2);
        px(1'b1, 0, 0, 4'b0000, 1'b0, 1'b0);
        idle(2);
        chk_zero("post_reset");

        idle(3);
        chk("sb_empty", 32'(sb.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
